// File: rtl/vlsu_cam_pkg.sv
// Shared parameters and types for the VLSU CAM allocation controller.
package vlsu_cam_pkg;
   localparam int DEPTH   = 16;
   localparam int INDEX   = $clog2(DEPTH);
   localparam int DATA    = 32;
   localparam int PAYLOAD = 8;
   localparam int READ    = 2;
   localparam int VIS_LAT = 3;

   typedef logic [INDEX-1:0]            index_t;
   typedef logic [INDEX:0]              count_t;
   typedef logic [DEPTH-1:0]            depth_t;
   typedef logic [DATA+PAYLOAD-1:0]     udata_t;
   typedef logic [DATA-1:0]             sdata_t;
   typedef logic [READ-1:0][DEPTH-1:0]  enable_t;

   // Circular increment; DEPTH need not be a power of two.
   function automatic index_t idx_inc(index_t i);
      return (i == index_t'(DEPTH-1)) ? '0 : index_t'(i + index_t'(1));
   endfunction
endpackage

// File: rtl/vlsu_cam_alloc_ctrl_if.sv
// Allocation/retire handshake and CAM write-side bundle.
// Optional flush_i exists only when VLSU_CAM_FLUSH_EN is defined.
interface vlsu_cam_alloc_ctrl_if;
   import vlsu_cam_pkg::*;

   logic    alloc_valid_i;
   logic    alloc_ready_o;
   udata_t  alloc_data_i;
   index_t  alloc_index_o;
   logic    retire_i;
`ifdef VLSU_CAM_FLUSH_EN
   logic    flush_i;
`endif
   logic    cam_write_o;
   index_t  cam_write_addr_o;
   udata_t  cam_write_data_o;
   index_t  cam_head_o;
   enable_t cam_enable_o;
   count_t  count_o;
   logic    full_o;
   logic    empty_o;

`ifdef VLSU_CAM_FLUSH_EN
   modport slave (
      input  alloc_valid_i, alloc_data_i, retire_i, flush_i,
      output alloc_ready_o, alloc_index_o, cam_write_o, cam_write_addr_o,
             cam_write_data_o, cam_head_o, cam_enable_o, count_o, full_o, empty_o
   );
   modport master (
      output alloc_valid_i, alloc_data_i, retire_i, flush_i,
      input  alloc_ready_o, alloc_index_o, cam_write_o, cam_write_addr_o,
             cam_write_data_o, cam_head_o, cam_enable_o, count_o, full_o, empty_o
   );
`else
   modport slave (
      input  alloc_valid_i, alloc_data_i, retire_i,
      output alloc_ready_o, alloc_index_o, cam_write_o, cam_write_addr_o,
             cam_write_data_o, cam_head_o, cam_enable_o, count_o, full_o, empty_o
   );
   modport master (
      output alloc_valid_i, alloc_data_i, retire_i,
      input  alloc_ready_o, alloc_index_o, cam_write_o, cam_write_addr_o,
             cam_write_data_o, cam_head_o, cam_enable_o, count_o, full_o, empty_o
   );
`endif
endinterface

// File: rtl/vlsu_cam_vis_pipe.sv
// Valid+index delay line; output is the index arriving this cycle, one cycle
// before it becomes visible. Synchronous clear and per-stage kill by index.
module vlsu_cam_vis_pipe
   import vlsu_cam_pkg::*;
#(
   parameter int STAGES = VIS_LAT - 1
) (
   input  logic   clk,
   input  logic   i_clr,
   input  logic   i_valid,
   input  index_t i_index,
   input  logic   i_kill,
   input  index_t i_kill_index,
   output logic   o_valid,
   output index_t o_index
);
   logic   [STAGES:0] vld_pipe;
   index_t [STAGES:0] w_idx;

   assign vld_pipe[0] = i_valid;
   assign w_idx[0]    = i_index;

   if (STAGES > 0) begin : g_stg
      logic   [STAGES:1] r_vld;
      index_t [STAGES:1] r_idx;

      always_ff @(posedge clk) begin
         if (i_clr) begin
            r_vld <= '0;
            r_idx <= '0;
         end else begin
            for (int s = 1; s <= STAGES; s++) begin
               r_vld[s] <= vld_pipe[s-1] && !(i_kill && (w_idx[s-1] == i_kill_index));
               r_idx[s] <= w_idx[s-1];
            end
         end
      end

      assign vld_pipe[STAGES:1] = r_vld;
      assign w_idx[STAGES:1]    = r_idx;
   end

   // A retire of the arriving index in the same cycle wins.
   assign o_valid = vld_pipe[STAGES] && !(i_kill && (w_idx[STAGES] == i_kill_index));
   assign o_index = w_idx[STAGES];
endmodule

// File: rtl/vlsu_cam_alloc_ctrl.sv
// Circular allocate/retire controller driving the VLSU CAM write side.
// Define VLSU_CAM_FLUSH_EN to add the flush_i clear input.
module vlsu_cam_alloc_ctrl
   import vlsu_cam_pkg::*;
(
   input logic                  clk,
   input logic                  rst,
   vlsu_cam_alloc_ctrl_if.slave bus
);
   index_t r_head, r_tail;
   count_t r_count;
   depth_t r_alloc, r_vis;
   logic   r_wr;
   index_t r_wr_addr;
   udata_t r_wr_data;

   logic   w_full, w_empty, w_accept, w_retire, w_flush, w_arr_vld;
   index_t w_arr_idx;

`ifdef VLSU_CAM_FLUSH_EN
   assign w_flush = bus.flush_i;
`else
   assign w_flush = 1'b0;
`endif

   assign w_full   = (r_count == count_t'(DEPTH));
   assign w_empty  = (r_count == '0);
   assign bus.alloc_ready_o = !w_full && !rst;
   assign w_accept = bus.alloc_valid_i && bus.alloc_ready_o;
   assign w_retire = bus.retire_i && !w_empty;

   vlsu_cam_vis_pipe u_vis (
      .clk          (clk),
      .i_clr        (rst || w_flush),
      .i_valid      (w_accept),
      .i_index      (r_tail),
      .i_kill       (w_retire),
      .i_kill_index (r_head),
      .o_valid      (w_arr_vld),
      .o_index      (w_arr_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_alloc   <= '0;
         r_vis     <= '0;
         r_wr      <= 1'b0;
         r_wr_addr <= '0;
         r_wr_data <= '0;
      end else if (w_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_alloc <= '0;
         r_vis   <= '0;
         r_wr    <= 1'b0;
      end else begin
         r_wr <= w_accept;
         if (w_accept) begin
            r_wr_addr        <= r_tail;
            r_wr_data        <= bus.alloc_data_i;
            r_alloc[r_tail]  <= 1'b1;
            r_tail           <= idx_inc(r_tail);
         end
         // Late visibility is dropped if the entry was retired meanwhile.
         if (w_arr_vld && r_alloc[w_arr_idx])
            r_vis[w_arr_idx] <= 1'b1;
         if (w_retire) begin
            r_alloc[r_head] <= 1'b0;
            r_vis[r_head]   <= 1'b0;
            r_head          <= idx_inc(r_head);
         end
         r_count <= r_count + count_t'(w_accept) - count_t'(w_retire);
      end
   end

   assign bus.alloc_index_o    = r_tail;
   assign bus.cam_write_o      = r_wr;
   assign bus.cam_write_addr_o = r_wr_addr;
   assign bus.cam_write_data_o = r_wr_data;
   assign bus.cam_head_o       = r_head;
   assign bus.cam_enable_o     = {READ{r_alloc & r_vis}};
   assign bus.count_o          = r_count;
   assign bus.full_o           = w_full;
   assign bus.empty_o          = w_empty;
endmodule
